// File: rtl/i2s_clk_ctrl.sv
// ============================================================================
//  Module      : i2s_clk_ctrl
//  Description : I2S master timing: divides mclk into sclk/lrclk, issues
//                one-mclk-early edge strobes and the per-frame sample handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_clk_ctrl #(
  parameter int MCLK_PER_SCLK  = 4,
  parameter int SCLK_PER_FRAME = 64,
  parameter int FCNT_W         = 16
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              i_enable,
  input  logic              i_sample_ready,
  input  logic              i_clear_overrun,
  output logic              o_sclk,
  output logic              o_lrclk,
  output logic              o_next_sclk_rise,
  output logic              o_next_sclk_fall,
  output logic              o_next_lrclk_rise,
  output logic              o_next_lrclk_fall,
  output logic              o_running,
  output logic              o_sample_valid,
  output logic              o_overrun,
  output logic [FCNT_W-1:0] o_frame_count
);

  localparam int c_half  = MCLK_PER_SCLK / 2;
  localparam int c_div_w = $clog2(MCLK_PER_SCLK);
  localparam int c_bit_w = $clog2(SCLK_PER_FRAME);

  localparam logic [c_div_w-1:0] c_div_max  = c_div_w'(MCLK_PER_SCLK - 1);
  localparam logic [c_div_w-1:0] c_div_rise = c_div_w'(c_half - 1);
  localparam logic [c_div_w-1:0] c_div_half = c_div_w'(c_half);
  localparam logic [c_bit_w-1:0] c_bit_max  = c_bit_w'(SCLK_PER_FRAME - 1);
  localparam logic [c_bit_w-1:0] c_bit_lr   = c_bit_w'(SCLK_PER_FRAME / 2 - 1);
  localparam logic [c_bit_w-1:0] c_bit_half = c_bit_w'(SCLK_PER_FRAME / 2);

  localparam logic [1:0] c_st_idle     = 2'd0;
  localparam logic [1:0] c_st_run      = 2'd1;
  localparam logic [1:0] c_st_stopping = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_div_w-1:0] r_div_cnt;
  logic [c_div_w-1:0] w_div_nxt;
  logic [c_bit_w-1:0] r_bit_cnt;
  logic [c_bit_w-1:0] w_bit_nxt;
  logic               r_sclk;
  logic               r_lrclk;
  logic               r_fill;
  logic               r_valid;
  logic               r_overrun;
  logic [FCNT_W-1:0]  r_frame_count;
  logic               w_running;
  logic               w_sclk_rise;
  logic               w_sclk_fall;
  logic               w_lrclk_rise;
  logic               w_lrclk_fall;
  logic               w_set;

  // FSM: state register
  always_ff @(posedge mclk) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state; re-enable while stopping takes precedence over the stop
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:     if (i_enable) w_state_nxt = c_st_run;
      c_st_run:      if (!i_enable) w_state_nxt = c_st_stopping;
      c_st_stopping: begin
        if (i_enable) begin
          w_state_nxt = c_st_run;
        end else if (w_lrclk_fall) begin
          w_state_nxt = c_st_idle;
        end
      end
      default:       w_state_nxt = c_st_idle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_running    = (r_state != c_st_idle);
    w_sclk_rise  = w_running && (r_div_cnt == c_div_rise);
    w_sclk_fall  = w_running && (r_div_cnt == c_div_max);
    w_lrclk_rise = w_sclk_fall && (r_bit_cnt == c_bit_lr);
    w_lrclk_fall = w_sclk_fall && (r_bit_cnt == c_bit_max);
  end

  // Counters only advance while running; the stop lands on the frame wrap,
  // so IDLE always begins with both counters at zero.
  always_comb begin
    w_div_nxt = '0;
    w_bit_nxt = '0;
    if (w_running) begin
      w_bit_nxt = r_bit_cnt;
      if (r_div_cnt == c_div_max) begin
        w_div_nxt = '0;
        w_bit_nxt = (r_bit_cnt == c_bit_max) ? '0 : r_bit_cnt + c_bit_w'(1);
      end else begin
        w_div_nxt = r_div_cnt + c_div_w'(1);
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_sclk    <= 1'b0;
      r_lrclk   <= 1'b0;
    end else begin
      r_div_cnt <= w_div_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_sclk    <= (w_div_nxt >= c_div_half);
      r_lrclk   <= (w_bit_nxt >= c_bit_half);
    end
  end

  // The first frame after start-up is only partially captured and is dropped.
  assign w_set = w_lrclk_fall && !r_fill;

  always_ff @(posedge mclk) begin
    if (reset) begin
      r_fill        <= 1'b1;
      r_valid       <= 1'b0;
      r_overrun     <= 1'b0;
      r_frame_count <= '0;
    end else begin
      if (!w_running) begin
        r_fill <= 1'b1;
      end else if (w_lrclk_fall) begin
        r_fill <= 1'b0;
      end

      if (w_set) begin
        r_valid <= 1'b1;
      end else if (r_valid && i_sample_ready) begin
        r_valid <= 1'b0;
      end

      if (w_set && r_valid && !i_sample_ready) begin
        r_overrun <= 1'b1;
      end else if (i_clear_overrun) begin
        r_overrun <= 1'b0;
      end

      if (w_lrclk_fall) begin
        r_frame_count <= r_frame_count + FCNT_W'(1);
      end
    end
  end

  assign o_sclk            = r_sclk;
  assign o_lrclk           = r_lrclk;
  assign o_next_sclk_rise  = w_sclk_rise;
  assign o_next_sclk_fall  = w_sclk_fall;
  assign o_next_lrclk_rise = w_lrclk_rise;
  assign o_next_lrclk_fall = w_lrclk_fall;
  assign o_running         = w_running;
  assign o_sample_valid    = r_valid;
  assign o_overrun         = r_overrun;
  assign o_frame_count     = r_frame_count;

endmodule

`default_nettype wire

// File: tb/tb_i2s_clk_ctrl.sv
// ============================================================================
//  Module      : tb_i2s_clk_ctrl
//  Description : Directed self-checking bench for i2s_clk_ctrl (default and
//                minimum-size configurations).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2s_clk_ctrl;

  logic        mclk = 1'b0;
  logic        reset, enable, ready, clear;
  logic        sclk, lrclk, sr, sf, lr, lf, running, valid, overrun;
  logic [15:0] fcount;

  logic        s_reset, s_enable;
  logic        s_sclk, s_lrclk, s_sr, s_sf, s_lr, s_lf, s_running, s_valid, s_overrun;
  logic [15:0] s_fcount;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int base   = 0;

  always #5 mclk = ~mclk;

  i2s_clk_ctrl dut (
    .mclk(mclk), .reset(reset), .i_enable(enable), .i_sample_ready(ready),
    .i_clear_overrun(clear), .o_sclk(sclk), .o_lrclk(lrclk),
    .o_next_sclk_rise(sr), .o_next_sclk_fall(sf), .o_next_lrclk_rise(lr),
    .o_next_lrclk_fall(lf), .o_running(running), .o_sample_valid(valid),
    .o_overrun(overrun), .o_frame_count(fcount)
  );

  i2s_clk_ctrl #(.MCLK_PER_SCLK(2), .SCLK_PER_FRAME(4), .FCNT_W(16)) dut_s (
    .mclk(mclk), .reset(s_reset), .i_enable(s_enable), .i_sample_ready(1'b0),
    .i_clear_overrun(1'b0), .o_sclk(s_sclk), .o_lrclk(s_lrclk),
    .o_next_sclk_rise(s_sr), .o_next_sclk_fall(s_sf), .o_next_lrclk_rise(s_lr),
    .o_next_lrclk_fall(s_lf), .o_running(s_running), .o_sample_valid(s_valid),
    .o_overrun(s_overrun), .o_frame_count(s_fcount)
  );

  task automatic step();
    @(posedge mclk);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int k);
    while (cyc < k) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; ready = 1'b1; clear = 1'b0;
    s_reset = 1'b1; s_enable = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("reset_outputs", {23'd0, sclk, lrclk, sr, sf, lr, lf, running, valid, overrun}, 32'd0);
    chk("reset_fcount", {16'd0, fcount}, 32'd0);

    // E0: enable sampled; the cycle after it is RUN cycle 0
    enable = 1'b1;
    step();
    cyc = 0;
    chk("run0_running", {31'd0, running}, 32'd1);
    chk("run0_clocks", {28'd0, sclk, lrclk, sr, sf}, 32'd0);
    step_to(1);   chk("sclk_rise_strobe", {31'd0, sr}, 32'd1);
    step_to(2);   chk("sclk_high", {30'd0, sclk, sr}, 32'd2);
    step_to(3);   chk("sclk_fall_strobe", {30'd0, sclk, sf}, 32'd3);
    step_to(4);   chk("sclk_low", {31'd0, sclk}, 32'd0);
    step_to(126); chk("lr_rise_early", {31'd0, lr}, 32'd0);
    step_to(127); chk("lr_rise_strobe", {30'd0, lrclk, lr}, 32'd1);
    step_to(128); chk("lrclk_high", {31'd0, lrclk}, 32'd1);
    step_to(255); chk("lr_fall_strobe", {30'd0, lrclk, lf}, 32'd3);
    chk("fcount_255", {16'd0, fcount}, 32'd0);
    step_to(256); chk("fill_suppressed", {30'd0, lrclk, valid}, 32'd0);
    chk("fcount_256", {16'd0, fcount}, 32'd1);
    step_to(511); chk("valid_before", {31'd0, valid}, 32'd0);
    step_to(512); chk("valid_512", {31'd0, valid}, 32'd1);
    step_to(513); chk("valid_consumed", {31'd0, valid}, 32'd0);
    step_to(767); chk("fcount_767", {16'd0, fcount}, 32'd2);
    step_to(768); chk("valid_768", {31'd0, valid}, 32'd1);
    chk("fcount_768", {16'd0, fcount}, 32'd3);
    step_to(769); chk("valid_769", {31'd0, valid}, 32'd0);
    ready = 1'b0;

    // Two set events with no consumer
    step_to(1024); chk("ovr_first", {30'd0, valid, overrun}, 32'd2);
    chk("fcount_1024", {16'd0, fcount}, 32'd4);
    step_to(1279); chk("ovr_before", {30'd0, valid, overrun}, 32'd2);
    step_to(1280); chk("ovr_second", {30'd0, valid, overrun}, 32'd3);
    step_to(1290); clear = 1'b1;
    step_to(1291); clear = 1'b0;
    chk("ovr_cleared", {30'd0, valid, overrun}, 32'd2);
    step_to(1535); chk("lf_1535", {31'd0, lf}, 32'd1);
    clear = 1'b1;
    step_to(1536); clear = 1'b0;
    chk("ovr_wins_clear", {30'd0, valid, overrun}, 32'd3);
    step_to(1540); clear = 1'b1;
    step_to(1541); clear = 1'b0; ready = 1'b1;
    chk("ovr_cleared2", {31'd0, overrun}, 32'd0);
    step_to(1542); chk("late_consume", {31'd0, valid}, 32'd0);

    // Stop request mid-frame
    step_to(1580); enable = 1'b0;
    step_to(1581); chk("stopping_running", {30'd0, running, sr}, 32'd3);
    step_to(1700); ready = 1'b0;
    step_to(1791); chk("last_lf", {30'd0, running, lf}, 32'd3);
    for (int c = 1792; c < 1850; c++) begin
      step_to(c);
      chk("idle_quiet", {25'd0, sclk, lrclk, sr, sf, lr, lf, running}, 32'd0);
      if (c == 1792) chk("idle_fcount", {16'd0, fcount}, 32'd7);
      if (c == 1800) begin
        chk("idle_valid_held", {31'd0, valid}, 32'd1);
        ready = 1'b1;
      end
      if (c == 1801) chk("idle_valid_consumed", {31'd0, valid}, 32'd0);
    end

    // Restart, then a drop/reassert that never reaches the frame boundary
    step_to(1850); enable = 1'b1;
    base = 1851;
    step_to(base);       chk("restart_run0", {29'd0, running, sclk, valid}, 32'd4);
    step_to(base + 255); chk("restart_lf", {31'd0, lf}, 32'd1);
    step_to(base + 256); chk("restart_fill", {31'd0, valid}, 32'd0);
    chk("restart_fcount", {16'd0, fcount}, 32'd8);
    step_to(base + 300); enable = 1'b0;
    step_to(base + 351); chk("glitch_stopping", {30'd0, running, sf}, 32'd3);
    step_to(base + 400); enable = 1'b1;
    step_to(base + 511); chk("glitch_lf", {31'd0, lf}, 32'd1);
    step_to(base + 512); chk("glitch_valid", {30'd0, running, valid}, 32'd3);
    chk("glitch_fcount", {16'd0, fcount}, 32'd9);
    step_to(base + 513); chk("glitch_consumed", {31'd0, valid}, 32'd0);
    step_to(base + 766); chk("period_early", {31'd0, lf}, 32'd0);
    step_to(base + 767); chk("period_256", {31'd0, lf}, 32'd1);

    // Minimum configuration: H=1, F=4
    chk("small_reset", {24'd0, s_sclk, s_lrclk, s_sr, s_sf, s_lr, s_lf, s_running, s_valid}, 32'd0);
    s_reset = 1'b0;
    step();
    base = cyc;
    for (int c = 0; c < 14; c++) begin
      step_to(base + c);
      chk("small_timing", {25'd0, s_running, s_sclk, s_lrclk, s_sr, s_sf, s_lr, s_lf},
          {25'd0, 1'b1, 1'(c % 2), 1'((c % 8) >= 4), 1'((c % 2) == 0),
           1'((c % 2) == 1), 1'((c % 8) == 3), 1'((c % 8) == 7)});
    end
    s_reset = 1'b1;
    step();
    chk("small_midreset", {22'd0, s_sclk, s_lrclk, s_sr, s_sf, s_lr, s_lf, s_running, s_valid,
        s_overrun, 1'b0}, 32'd0);
    chk("small_midreset_fc", {16'd0, s_fcount}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
